// File: rtl/zeroriscy_lsu_split_pkg.sv
// Shared LSU definitions: FSM state encoding, access-type codes (also used by
// the decoder) and helpers for byte-enable and misalignment computation.
package zeroriscy_lsu_split_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRST_GNT,
        FIRST_RSP,
        SECOND_GNT,
        SECOND_RSP
    } lsu_state_e;

    localparam logic [1:0] LSU_TYPE_WORD = 2'b00;
    localparam logic [1:0] LSU_TYPE_HALF = 2'b01;
    localparam logic [1:0] LSU_TYPE_BYTE = 2'b10;

    // Byte enables across two consecutive words: low nibble for the first
    // aligned word, high nibble for the following word. Reserved type 11 acts as word.
    function automatic logic [7:0] lsuBe8(input logic [1:0] dataType, input logic [1:0] off);
        logic [7:0] base;
        case (dataType)
            LSU_TYPE_HALF: base = 8'b0000_0011;
            LSU_TYPE_BYTE: base = 8'b0000_0001;
            default:       base = 8'b0000_1111;
        endcase
        return base << off;
    endfunction

    // An access is misaligned when it spills into the next word.
    function automatic logic lsuMisaligned(input logic [1:0] dataType, input logic [1:0] off);
        logic isWord;
        logic isHalf;
        isWord = (dataType != LSU_TYPE_HALF) && (dataType != LSU_TYPE_BYTE);
        isHalf = (dataType == LSU_TYPE_HALF);
        return (isWord && (off != 2'b00)) || (isHalf && (off == 2'b11));
    endfunction

endpackage

// File: rtl/zeroriscy_lsu_rdata_align.sv
// Load-data alignment: shifts the addressed bytes down to bit 0 (optionally
// across two words for a split access) and zero/sign-extends byte and half loads.
module zeroriscy_lsu_rdata_align
    import zeroriscy_lsu_split_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] rdataPrev_i,
    input  logic        split_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  dataType_i,
    input  logic        signExt_i,
    output logic [31:0] rdata_o
);

    logic [63:0] window;
    logic [31:0] raw;

    // Build the byte window, shift by the byte offset, then extend to 32 bits.
    always_comb begin
        window  = split_i ? {rdata_i, rdataPrev_i} : {32'h0, rdata_i};
        window  = window >> {off_i, 3'b000};
        raw     = window[31:0];
        rdata_o = raw;
        case (dataType_i)
            LSU_TYPE_BYTE: rdata_o = {{24{signExt_i & raw[7]}}, raw[7:0]};
            LSU_TYPE_HALF: rdata_o = {{16{signExt_i & raw[15]}}, raw[15:0]};
            default:       rdata_o = raw;
        endcase
    end

endmodule

// File: rtl/zeroriscy_lsu_split.sv
// Data-side load/store unit: OBI-style req/gnt/rvalid handshake with one
// outstanding transaction; misaligned word/half accesses are split into two
// aligned word transactions and the load data recombined.
module zeroriscy_lsu_split
    import zeroriscy_lsu_split_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit SUPPORT_MIS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_en_i,
    input  logic              data_we_ex_i,
    input  logic [1:0]        data_type_ex_i,
    input  logic              data_sign_ext_ex_i,
    input  logic [ADDR_W-1:0] data_addr_ex_i,
    input  logic [31:0]       data_wdata_ex_i,
    output logic              lsu_ready_ex_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_err_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    input  logic              data_err_i
);

    lsu_state_e        state_q;
    logic [31:0]       rdata_q;
    logic              rejectPend_q;

    logic [1:0]        off;
    logic [7:0]        be8;
    logic              mis;
    logic              splitNeeded;
    logic              reject;
    logic              startReq;
    logic              isSecond;
    logic [ADDR_W-1:0] firstAddr;
    logic [ADDR_W-1:0] secondAddr;
    logic [63:0]       wdataDouble;
    logic [31:0]       alignedRdata;

    // EX holds address/type/data stable for the whole access, so the bus
    // fields can be derived directly from them and stay stable until grant.
    assign off          = data_addr_ex_i[1:0];
    assign be8          = lsuBe8(data_type_ex_i, off);
    assign mis          = lsuMisaligned(data_type_ex_i, off);
    assign splitNeeded  = mis && SUPPORT_MIS;
    assign reject       = mis && !SUPPORT_MIS;
    assign firstAddr    = {data_addr_ex_i[ADDR_W-1:2], 2'b00};
    assign secondAddr   = firstAddr + ADDR_W'(4);
    assign isSecond     = (state_q == SECOND_GNT) || (state_q == SECOND_RSP);
    assign startReq     = (state_q == IDLE) && lsu_en_i && !reject && !rejectPend_q;
    assign wdataDouble  = {data_wdata_ex_i, data_wdata_ex_i} << {off, 3'b000};

    assign data_req_o   = startReq || (state_q == FIRST_GNT) || (state_q == SECOND_GNT);
    assign data_addr_o  = isSecond ? secondAddr : firstAddr;
    assign data_be_o    = isSecond ? be8[7:4] : be8[3:0];
    assign data_we_o    = data_we_ex_i;
    assign data_wdata_o = wdataDouble[63:32];

    // Access state, captured first-word data and the misaligned-reject pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rdata_q      <= 32'h0;
            rejectPend_q <= 1'b0;
        end else begin
            rejectPend_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lsu_en_i && !rejectPend_q) begin
                        if (reject) begin
                            rejectPend_q <= 1'b1;
                        end else if (data_gnt_i) begin
                            state_q <= FIRST_RSP;
                        end else begin
                            state_q <= FIRST_GNT;
                        end
                    end
                end
                FIRST_GNT: begin
                    if (data_gnt_i) begin
                        state_q <= FIRST_RSP;
                    end
                end
                FIRST_RSP: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            state_q <= IDLE;
                        end else if (splitNeeded) begin
                            rdata_q <= data_rdata_i;
                            state_q <= SECOND_GNT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                SECOND_GNT: begin
                    if (data_gnt_i) begin
                        state_q <= SECOND_RSP;
                    end
                end
                SECOND_RSP: begin
                    if (data_rvalid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completion is signalled in the cycle of the final response.
    always_comb begin
        lsu_ready_ex_o = 1'b0;
        lsu_err_o      = 1'b0;
        if (rejectPend_q) begin
            lsu_ready_ex_o = 1'b1;
            lsu_err_o      = 1'b1;
        end
        case (state_q)
            FIRST_RSP: begin
                if (data_rvalid_i && (data_err_i || !splitNeeded)) begin
                    lsu_ready_ex_o = 1'b1;
                    lsu_err_o      = data_err_i;
                end
            end
            SECOND_RSP: begin
                if (data_rvalid_i) begin
                    lsu_ready_ex_o = 1'b1;
                    lsu_err_o      = data_err_i;
                end
            end
            default: ;
        endcase
    end

    zeroriscy_lsu_rdata_align u_rdata_align (
        .rdata_i     (data_rdata_i),
        .rdataPrev_i (rdata_q),
        .split_i     (state_q == SECOND_RSP),
        .off_i       (off),
        .dataType_i  (data_type_ex_i),
        .signExt_i   (data_sign_ext_ex_i),
        .rdata_o     (alignedRdata)
    );

    assign lsu_rdata_o = data_we_ex_i ? 32'h0 : alignedRdata;

    // EX must keep the access presented until the LSU acknowledges it.
    enHeld: assert property (@(posedge clk) disable iff (rst)
        ((state_q != IDLE) || rejectPend_q) |-> lsu_en_i);

endmodule

// File: tb/tb_zeroriscy_lsu_split.sv
// Table-driven bench for zeroriscy_lsu_split with a scoreboard of expected
// load results, plus hand-written reset-during-transaction sequences.
module tb_zeroriscy_lsu_split;

    logic        clk;
    logic        rst;
    logic        lsuEn;
    logic        dataWeEx;
    logic [1:0]  dataTypeEx;
    logic        dataSignExt;
    logic [31:0] dataAddrEx;
    logic [31:0] dataWdataEx;
    logic        lsuReady;
    logic [31:0] lsuRdata;
    logic        lsuErr;
    logic        dataReq;
    logic        dataGnt;
    logic [31:0] dataAddr;
    logic        dataWe;
    logic [3:0]  dataBe;
    logic [31:0] dataWdata;
    logic        dataRvalid;
    logic [31:0] dataRdata;
    logic        dataErr;

    int checkCount = 0;
    int errCount   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  dtype;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gntDelay;
        logic [31:0] rdata1;
        logic        err1;
        logic [31:0] rdata2;
        logic        err2;
        logic        split;
        logic [3:0]  be1;
        logic [3:0]  be2;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
        logic        expErr;
        logic        chkRdata;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chkRdata;
    } exp_t;

    vec_t vecs[13];
    exp_t expQ[$];

    zeroriscy_lsu_split dut (
        .clk                (clk),
        .rst                (rst),
        .lsu_en_i           (lsuEn),
        .data_we_ex_i       (dataWeEx),
        .data_type_ex_i     (dataTypeEx),
        .data_sign_ext_ex_i (dataSignExt),
        .data_addr_ex_i     (dataAddrEx),
        .data_wdata_ex_i    (dataWdataEx),
        .lsu_ready_ex_o     (lsuReady),
        .lsu_rdata_o        (lsuRdata),
        .lsu_err_o          (lsuErr),
        .data_req_o         (dataReq),
        .data_gnt_i         (dataGnt),
        .data_addr_o        (dataAddr),
        .data_we_o          (dataWe),
        .data_be_o          (dataBe),
        .data_wdata_o       (dataWdata),
        .data_rvalid_i      (dataRvalid),
        .data_rdata_i       (dataRdata),
        .data_err_i         (dataErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Completion must be flagged now; compare against the oldest expected result.
    task automatic checkResult(input int idx);
        exp_t e;
        checkOutput($sformatf("ready[%0d]", idx), lsuReady, 1);
        if (lsuReady === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errCount++;
                $display("[TB] FAIL scoreboard[%0d]: got a completion, expected none pending", idx);
            end else begin
                e = expQ.pop_front();
                if (e.chkRdata) checkOutput($sformatf("rdata[%0d]", idx), lsuRdata, e.rdata);
                checkOutput($sformatf("err[%0d]", idx), lsuErr, e.err);
            end
        end
    endtask

    // Drive one access and act as the memory side, checking the bus cycle by cycle.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        lsuEn       = 1'b1;
        dataWeEx    = v.we;
        dataTypeEx  = v.dtype;
        dataSignExt = v.sext;
        dataAddrEx  = v.addr;
        dataWdataEx = v.wdata;
        dataGnt     = (v.gntDelay == 0);
        e.rdata     = v.expRdata;
        e.err       = v.expErr;
        e.chkRdata  = v.chkRdata;
        expQ.push_back(e);
        for (int d = 0; d <= v.gntDelay; d++) begin
            if (d > 0) begin
                @(negedge clk);
                dataGnt = (d == v.gntDelay);
            end
            #1;
            checkOutput($sformatf("req1[%0d]", idx), dataReq, 1);
            checkOutput($sformatf("addr1[%0d]", idx), dataAddr, v.addr & ~32'd3);
            checkOutput($sformatf("be1[%0d]", idx), dataBe, v.be1);
            checkOutput($sformatf("we1[%0d]", idx), dataWe, v.we);
            if (v.we) checkOutput($sformatf("wdata1[%0d]", idx), dataWdata, v.expWdata);
            checkOutput($sformatf("readyEarly[%0d]", idx), lsuReady, 0);
        end
        @(negedge clk);
        dataGnt    = 1'b0;
        dataRvalid = 1'b1;
        dataRdata  = v.rdata1;
        dataErr    = v.err1;
        #1;
        if (v.split && !v.err1) begin
            checkOutput($sformatf("readyMid[%0d]", idx), lsuReady, 0);
            checkOutput($sformatf("reqGap[%0d]", idx), dataReq, 0);
            @(negedge clk);
            dataRvalid = 1'b0;
            dataRdata  = 32'h0;
            dataErr    = 1'b0;
            dataGnt    = 1'b1;
            #1;
            checkOutput($sformatf("req2[%0d]", idx), dataReq, 1);
            checkOutput($sformatf("addr2[%0d]", idx), dataAddr, (v.addr & ~32'd3) + 32'd4);
            checkOutput($sformatf("be2[%0d]", idx), dataBe, v.be2);
            if (v.we) checkOutput($sformatf("wdata2[%0d]", idx), dataWdata, v.expWdata);
            checkOutput($sformatf("readyGnt2[%0d]", idx), lsuReady, 0);
            @(negedge clk);
            dataGnt    = 1'b0;
            dataRvalid = 1'b1;
            dataRdata  = v.rdata2;
            dataErr    = v.err2;
            #1;
        end
        checkResult(idx);
        @(negedge clk);
        dataRvalid = 1'b0;
        dataRdata  = 32'h0;
        dataErr    = 1'b0;
        lsuEn      = 1'b0;
        #1;
        checkOutput($sformatf("readyOnce[%0d]", idx), lsuReady, 0);
        checkOutput($sformatf("reqIdle[%0d]", idx), dataReq, 0);
    endtask

    initial begin
        // we, type, sext, addr, wdata, gntDelay, rdata1, err1, rdata2, err2, split, be1, be2, expWdata, expRdata, expErr, chkRdata
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 4'b1111, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 0, 32'h44332211, 1'b0, 32'h88776655, 1'b0, 1'b1, 4'b1110, 4'b0001, 32'h0, 32'h55443322, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 2'b01, 1'b0, 32'h1003, 32'h0000ABCD, 0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 4'b1000, 4'b0001, 32'hCD0000AB, 32'h0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 2'b10, 1'b1, 32'h1002, 32'h0, 0, 32'h00800000, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0100, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 0, 32'h00800000, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0100, 4'b0000, 32'h0, 32'h00000080, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h2000, 32'h0, 3, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0, 4'b1111, 4'b0000, 32'h0, 32'h12345678, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 3, 32'h44332211, 1'b1, 32'h0, 1'b0, 1'b1, 4'b1110, 4'b0001, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h1002, 32'h0, 0, 32'h80010000, 1'b0, 32'h0, 1'b0, 1'b0, 4'b1100, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h1003, 32'h0, 1, 32'hAB000000, 1'b0, 32'h000000CD, 1'b0, 1'b1, 4'b1000, 4'b0001, 32'h0, 32'h0000CDAB, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h1001, 32'h000000EE, 0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0010, 4'b0000, 32'h0000EE00, 32'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h1002, 32'h11223344, 2, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 4'b1100, 4'b0011, 32'h33441122, 32'h0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 0, 32'hDDCCBBAA, 1'b0, 32'h00000011, 1'b1, 1'b1, 4'b1000, 4'b0111, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h1001, 32'h0, 0, 32'h00FF7F00, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0110, 4'b0000, 32'h0, 32'hFFFFFF7F, 1'b0, 1'b1};

        rst         = 1'b1;
        lsuEn       = 1'b0;
        dataWeEx    = 1'b0;
        dataTypeEx  = 2'b00;
        dataSignExt = 1'b0;
        dataAddrEx  = 32'h0;
        dataWdataEx = 32'h0;
        dataGnt     = 1'b0;
        dataRvalid  = 1'b0;
        dataRdata   = 32'h0;
        dataErr     = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetReq", dataReq, 0);
        checkOutput("resetReady", lsuReady, 0);
        checkOutput("resetErr", lsuErr, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset while waiting for grant: request must drop immediately.
        @(negedge clk);
        lsuEn      = 1'b1;
        dataWeEx   = 1'b0;
        dataTypeEx = 2'b00;
        dataAddrEx = 32'h3000;
        dataGnt    = 1'b0;
        #1;
        checkOutput("rstGntReq", dataReq, 1);
        @(negedge clk);
        #1;
        checkOutput("rstGntHeld", dataReq, 1);
        @(negedge clk);
        rst   = 1'b1;
        lsuEn = 1'b0;
        #1;
        checkOutput("rstGntDrop", dataReq, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while waiting for the response: a late rvalid must be ignored.
        @(negedge clk);
        lsuEn      = 1'b1;
        dataAddrEx = 32'h3004;
        dataGnt    = 1'b1;
        #1;
        checkOutput("rstRspReq", dataReq, 1);
        @(negedge clk);
        dataGnt = 1'b0;
        #1;
        checkOutput("rstRspWait", dataReq, 0);
        @(negedge clk);
        rst   = 1'b1;
        lsuEn = 1'b0;
        #1;
        checkOutput("rstRspReady", lsuReady, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dataRvalid = 1'b1;
        dataRdata  = 32'hCAFEF00D;
        #1;
        checkOutput("lateRvalidReady", lsuReady, 0);
        checkOutput("lateRvalidReq", dataReq, 0);
        @(negedge clk);
        dataRvalid = 1'b0;
        dataRdata  = 32'h0;

        applyStimulus(vecs[0], 100);
        applyStimulus(vecs[1], 101);

        checkOutput("scoreboardEmpty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
